// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller and its scoreboard.
// A scoreboard entry records one in-flight register write as {valid, dest}.
package pipeline_hazard_controller_pkg;

    localparam int         SB_ENTRY_W = 6;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hazardState_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
    } sbEntry_t;

    // $0 is hardwired to zero, so writes to it never create a dependency
    function automatic sbEntry_t makeEntry(input logic regWrite, input logic [4:0] dest);
        sbEntry_t e;
        e.valid = regWrite && (dest != REG_ZERO);
        e.dest  = dest;
        return e;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry destination scoreboard tracking writes in EX, MEM and WB,
// compared against the ID instruction's source registers to flag RAW hazards.
module hazard_scoreboard
    import pipeline_hazard_controller_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       idValid,
    input  logic [4:0] readReg1,
    input  logic [4:0] readReg2,
    input  logic       usesRs,
    input  logic       usesRt,
    input  logic       idRegWrite,
    input  logic [4:0] idDest,
    input  logic       squashEx,
    input  logic       squashMem,
    output logic       hazard
);

    sbEntry_t sbEx, sbMem, sbWb, idEntry;
    logic     exHit, memHit, wbHit;

    assign idEntry = makeEntry(idRegWrite, idDest);

    function automatic logic readsEntry(input sbEntry_t e, input logic uses, input logic [4:0] r);
        return uses && (r != REG_ZERO) && e.valid && (e.dest == r);
    endfunction

    // Squashed slots become bubbles so a flushed or stalled instruction never blocks others
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sbEx  <= '0;
            sbMem <= '0;
            sbWb  <= '0;
        end else begin
            sbWb  <= sbMem;
            sbMem <= squashMem ? '0 : sbEx;
            sbEx  <= squashEx ? '0 : idEntry;
        end
    end

    always_comb begin
        exHit  = readsEntry(sbEx, usesRs, readReg1) || readsEntry(sbEx, usesRt, readReg2);
        memHit = readsEntry(sbMem, usesRs, readReg1) || readsEntry(sbMem, usesRt, readReg2);
        wbHit  = 1'b0;
        if (!WB_BYPASS) begin
            wbHit = readsEntry(sbWb, usesRs, readReg1) || readsEntry(sbWb, usesRt, readReg2);
        end
        hazard = idValid && (exHit || memHit || wbHit);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline without forwarding,
// with stall/flush performance counters and a stall-run watchdog.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int WB_BYPASS   = 0,
    parameter int STALL_LIMIT = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_IDValid,
    input  logic [4:0]           in_ReadReg1_5,
    input  logic [4:0]           in_ReadReg2_5,
    input  logic                 in_UsesRs,
    input  logic                 in_UsesRt,
    input  logic                 in_IDRegWrite,
    input  logic [4:0]           in_IDDest_5,
    input  logic                 in_EXJump,
    input  logic                 in_MEMBranchTaken,
    output logic                 o_PCEnable,
    output logic                 o_IF_ID_Enable,
    output logic                 o_IF_ID_Flush,
    output logic                 o_ID_EX_Flush,
    output logic                 o_EX_MEM_Flush,
    output logic [1:0]           o_State_2,
    output logic [CNT_WIDTH-1:0] o_StallCount,
    output logic [CNT_WIDTH-1:0] o_FlushCount,
    output logic                 o_Error
);

    localparam int               RUN_W    = $clog2(STALL_LIMIT + 2);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(STALL_LIMIT);

    hazardState_t         state, nextState;
    logic                 hazard, branchFlush, jumpFlush, anyFlush, stall;
    logic [RUN_W-1:0]     stallRun;
    logic [CNT_WIDTH-1:0] stallCount, flushCount;
    logic                 errorFlag;

    // Branch outranks jump, and either outranks a stall
    assign branchFlush = in_MEMBranchTaken;
    assign jumpFlush   = in_EXJump & ~in_MEMBranchTaken;
    assign anyFlush    = in_MEMBranchTaken | in_EXJump;
    assign stall       = hazard & ~anyFlush;

    hazard_scoreboard #(
        .WB_BYPASS (WB_BYPASS != 0)
    ) uScoreboard (
        .clk        (clk),
        .reset      (reset),
        .idValid    (in_IDValid),
        .readReg1   (in_ReadReg1_5),
        .readReg2   (in_ReadReg2_5),
        .usesRs     (in_UsesRs),
        .usesRt     (in_UsesRt),
        .idRegWrite (in_IDRegWrite),
        .idDest     (in_IDDest_5),
        .squashEx   (anyFlush | stall),
        .squashMem  (branchFlush),
        .hazard     (hazard)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = ST_RUN;
        if (anyFlush) begin
            nextState = ST_FLUSH;
        end else if (stall) begin
            nextState = ST_STALL;
        end
    end

    // Control outputs respond in the same cycle; reset forces the free-running pattern
    always_comb begin
        o_PCEnable     = 1'b1;
        o_IF_ID_Enable = 1'b1;
        o_IF_ID_Flush  = 1'b0;
        o_ID_EX_Flush  = 1'b0;
        o_EX_MEM_Flush = 1'b0;
        if (reset) begin
            if (branchFlush) begin
                o_IF_ID_Flush  = 1'b1;
                o_ID_EX_Flush  = 1'b1;
                o_EX_MEM_Flush = 1'b1;
            end else if (jumpFlush) begin
                o_IF_ID_Flush = 1'b1;
                o_ID_EX_Flush = 1'b1;
            end else if (stall) begin
                o_PCEnable     = 1'b0;
                o_IF_ID_Enable = 1'b0;
                o_ID_EX_Flush  = 1'b1;
            end
        end
    end

    // The run counter saturates just past the limit so long stalls cannot wrap it back under
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCount <= '0;
            flushCount <= '0;
            stallRun   <= '0;
            errorFlag  <= 1'b0;
        end else begin
            if (stall) begin
                stallCount <= stallCount + CNT_WIDTH'(1);
            end
            if (anyFlush) begin
                flushCount <= flushCount + CNT_WIDTH'(1);
            end
            if (!stall) begin
                stallRun <= '0;
            end else if (stallRun != RUN_MAX) begin
                stallRun <= stallRun + RUN_W'(1);
            end
            if (stall && (stallRun >= RUN_TRIP)) begin
                errorFlag <= 1'b1;
            end
        end
    end

    assign o_State_2    = state;
    assign o_StallCount = stallCount;
    assign o_FlushCount = flushCount;
    assign o_Error      = errorFlag;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: three configurations share one stimulus stream
// and are checked against a behavioural model through an expectation queue.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       idValid, usesRs, usesRt, idRegWrite, exJump, memBranch;
    logic [4:0] rs, rt, idDest;

    logic        pcEn [3];
    logic        ifIdEn [3];
    logic        ifIdFl [3];
    logic        idExFl [3];
    logic        exMemFl [3];
    logic        err [3];
    logic [1:0]  st [3];
    logic [31:0] stallC [3];
    logic [31:0] flushC [3];

    always #5 clk = ~clk;

    // u0: reference config, u1: write-before-read regfile, u2: tighter watchdog
    pipeline_hazard_controller #(.WB_BYPASS(0), .STALL_LIMIT(3), .CNT_WIDTH(32)) u0 (
        .clk(clk), .reset(reset), .in_IDValid(idValid), .in_ReadReg1_5(rs), .in_ReadReg2_5(rt),
        .in_UsesRs(usesRs), .in_UsesRt(usesRt), .in_IDRegWrite(idRegWrite), .in_IDDest_5(idDest),
        .in_EXJump(exJump), .in_MEMBranchTaken(memBranch), .o_PCEnable(pcEn[0]),
        .o_IF_ID_Enable(ifIdEn[0]), .o_IF_ID_Flush(ifIdFl[0]), .o_ID_EX_Flush(idExFl[0]),
        .o_EX_MEM_Flush(exMemFl[0]), .o_State_2(st[0]), .o_StallCount(stallC[0]),
        .o_FlushCount(flushC[0]), .o_Error(err[0]));

    pipeline_hazard_controller #(.WB_BYPASS(1), .STALL_LIMIT(3), .CNT_WIDTH(32)) u1 (
        .clk(clk), .reset(reset), .in_IDValid(idValid), .in_ReadReg1_5(rs), .in_ReadReg2_5(rt),
        .in_UsesRs(usesRs), .in_UsesRt(usesRt), .in_IDRegWrite(idRegWrite), .in_IDDest_5(idDest),
        .in_EXJump(exJump), .in_MEMBranchTaken(memBranch), .o_PCEnable(pcEn[1]),
        .o_IF_ID_Enable(ifIdEn[1]), .o_IF_ID_Flush(ifIdFl[1]), .o_ID_EX_Flush(idExFl[1]),
        .o_EX_MEM_Flush(exMemFl[1]), .o_State_2(st[1]), .o_StallCount(stallC[1]),
        .o_FlushCount(flushC[1]), .o_Error(err[1]));

    pipeline_hazard_controller #(.WB_BYPASS(0), .STALL_LIMIT(2), .CNT_WIDTH(32)) u2 (
        .clk(clk), .reset(reset), .in_IDValid(idValid), .in_ReadReg1_5(rs), .in_ReadReg2_5(rt),
        .in_UsesRs(usesRs), .in_UsesRt(usesRt), .in_IDRegWrite(idRegWrite), .in_IDDest_5(idDest),
        .in_EXJump(exJump), .in_MEMBranchTaken(memBranch), .o_PCEnable(pcEn[2]),
        .o_IF_ID_Enable(ifIdEn[2]), .o_IF_ID_Flush(ifIdFl[2]), .o_ID_EX_Flush(idExFl[2]),
        .o_EX_MEM_Flush(exMemFl[2]), .o_State_2(st[2]), .o_StallCount(stallC[2]),
        .o_FlushCount(flushC[2]), .o_Error(err[2]));

    typedef struct {
        string      tag;
        int         inst;
        logic       pcEn, ifIdEn, ifIdFl, idExFl, exMemFl, err;
        logic [1:0] st;
        int         stallC, flushC;
    } expect_t;

    expect_t expQ[$];

    int cfgBypass [3] = '{0, 1, 0};
    int cfgLimit  [3] = '{3, 3, 2};

    bit         mV [3][3];
    logic [4:0] mD [3][3];
    int         mState [3];
    int         mStall [3];
    int         mFlush [3];
    int         mRun [3];
    bit         mErr [3];

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 3; s++) begin
                mV[k][s] = 1'b0;
                mD[k][s] = 5'd0;
            end
            mState[k] = 0;
            mStall[k] = 0;
            mFlush[k] = 0;
            mRun[k]   = 0;
            mErr[k]   = 1'b0;
        end
    endtask

    // Stage index 0 = EX, 1 = MEM, 2 = WB
    function automatic bit modelHazard(input int k);
        bit h = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (!(s == 2 && cfgBypass[k] != 0) && mV[k][s]) begin
                if (usesRs && rs != 5'd0 && rs == mD[k][s]) h = 1'b1;
                if (usesRt && rt != 5'd0 && rt == mD[k][s]) h = 1'b1;
            end
        end
        return idValid && h;
    endfunction

    task automatic modelEdge();
        bit hz, stl, fl;
        if (!reset) return;
        for (int k = 0; k < 3; k++) begin
            hz  = modelHazard(k);
            fl  = memBranch || exJump;
            stl = hz && !fl;
            mV[k][2] = mV[k][1];
            mD[k][2] = mD[k][1];
            mV[k][1] = memBranch ? 1'b0 : mV[k][0];
            mD[k][1] = mD[k][0];
            mV[k][0] = (fl || stl) ? 1'b0 : (idRegWrite && idDest != 5'd0);
            mD[k][0] = idDest;
            mState[k] = fl ? 2 : (stl ? 1 : 0);
            if (stl) mStall[k]++;
            if (fl)  mFlush[k]++;
            if (stl && mRun[k] >= cfgLimit[k]) mErr[k] = 1'b1;
            mRun[k] = stl ? mRun[k] + 1 : 0;
        end
    endtask

    task automatic applyStimulus(input string tag, input bit v, input logic [4:0] r1, input logic [4:0] r2,
                                 input bit u1, input bit u2, input bit wr, input logic [4:0] d,
                                 input bit j, input bit b);
        expect_t e;
        bit hz, stl, fl;
        idValid = v; rs = r1; rt = r2; usesRs = u1; usesRt = u2;
        idRegWrite = wr; idDest = d; exJump = j; memBranch = b;
        for (int k = 0; k < 3; k++) begin
            hz  = modelHazard(k);
            fl  = (b || j) && reset;
            stl = hz && !(b || j) && reset;
            e.tag     = tag;
            e.inst    = k;
            e.pcEn    = !stl;
            e.ifIdEn  = !stl;
            e.ifIdFl  = fl;
            e.idExFl  = fl || stl;
            e.exMemFl = b && reset;
            e.st      = 2'(mState[k]);
            e.stallC  = mStall[k];
            e.flushC  = mFlush[k];
            e.err     = mErr[k];
            expQ.push_back(e);
        end
    endtask

    task automatic sampleOutputs();
        expect_t e;
        string   p;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            p = $sformatf("%s/u%0d", e.tag, e.inst);
            checkOutput({p, "/pcEn"},    32'(pcEn[e.inst]),    32'(e.pcEn));
            checkOutput({p, "/ifIdEn"},  32'(ifIdEn[e.inst]),  32'(e.ifIdEn));
            checkOutput({p, "/ifIdFl"},  32'(ifIdFl[e.inst]),  32'(e.ifIdFl));
            checkOutput({p, "/idExFl"},  32'(idExFl[e.inst]),  32'(e.idExFl));
            checkOutput({p, "/exMemFl"}, 32'(exMemFl[e.inst]), 32'(e.exMemFl));
            checkOutput({p, "/state"},   32'(st[e.inst]),      32'(e.st));
            checkOutput({p, "/stallCnt"}, stallC[e.inst],      32'(e.stallC));
            checkOutput({p, "/flushCnt"}, flushC[e.inst],      32'(e.flushC));
            checkOutput({p, "/error"},   32'(err[e.inst]),     32'(e.err));
        end
    endtask

    // Called one time unit after a rising edge; returns one time unit after the next
    task automatic stepCycle(input string tag, input bit v, input logic [4:0] r1, input logic [4:0] r2,
                             input bit u1, input bit u2, input bit wr, input logic [4:0] d,
                             input bit j, input bit b);
        applyStimulus(tag, v, r1, r2, u1, u2, wr, d, j, b);
        #3;
        sampleOutputs();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic midCycleReset(input string tag);
        reset = 1'b0;
        #1;
        modelReset();
        applyStimulus(tag, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1);
        #1;
        sampleOutputs();
        @(posedge clk);
        #1;
        applyStimulus("idle", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        expQ.delete();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        modelReset();
        applyStimulus("reset", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        sampleOutputs();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Producer of $3, then a consumer of $3 held in ID
        stepCycle("load3", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepCycle($sformatf("raw3_%0d", i), 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        end
        stepCycle("after3", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Writes to $0 never register
        stepCycle("wr0",  1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        stepCycle("rd0",  1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // Taken branch overrides a pending hazard
        stepCycle("load7",  1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        stepCycle("br7",    1'b1, 5'd8, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        stepCycle("post7",  1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // Jump alone, then jump and branch together
        stepCycle("load9",  1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        stepCycle("jmp9",   1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0);
        stepCycle("post9",  1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        stepCycle("jmpbr",  1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        stepCycle("postjb", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset arriving during a flush with a stall also pending
        stepCycle("load7b", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        stepCycle("brpend", 1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        midCycleReset("midReset");
        stepCycle("postRst", 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // Dense dependencies on a few registers with occasional control transfers
        for (int i = 0; i < 60; i++) begin
            bit         v;
            logic [4:0] a, b2, d;
            v  = ($urandom_range(0, 3) != 0);
            a  = 5'($urandom_range(0, 3));
            b2 = 5'($urandom_range(0, 3));
            d  = 5'($urandom_range(0, 3));
            stepCycle($sformatf("rnd%0d", i), v, a, b2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      v && ($urandom_range(0, 1) != 0), d,
                      ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage MIPS pipeline, which has no forwarding path.
- Keeps a 3-entry destination scoreboard covering the EX, MEM and WB stages.
- Stalls IF/ID and injects bubbles into ID/EX on read-after-write hazards.
- Flushes younger stages on taken branches (resolved in MEM) and on jumps / jr (resolved in EX).
- Sits beside the control unit; drives the PC and pipeline-register enable/clear inputs, plus perf counters and a deadlock watchdog.

Parameters:
WB_BYPASS, 0, 1 = register file is write-before-read, so the WB entry never causes a hazard
STALL_LIMIT, 3, consecutive stall cycles allowed before o_Error is set
CNT_WIDTH, 32, width of the stall and flush counters

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
in_IDValid  in  1  IF/ID holds a real instruction
in_ReadReg1_5  in  5  rs of the ID instruction
in_ReadReg2_5  in  5  rt of the ID instruction
in_UsesRs  in  1  ID instruction reads rs
in_UsesRt  in  1  ID instruction reads rt
in_IDRegWrite  in  1  ID instruction writes the register file
in_IDDest_5  in  5  ID destination, already RegDst/jal-resolved
in_EXJump  in  1  j/jal/jr resolved in EX this cycle
in_MEMBranchTaken  in  1  branch condition true in MEM this cycle
o_PCEnable  out  1  PC load enable
o_IF_ID_Enable  out  1  IF/ID load enable
o_IF_ID_Flush  out  1  clear IF/ID at the next edge
o_ID_EX_Flush  out  1  clear ID/EX control bits at the next edge (bubble)
o_EX_MEM_Flush  out  1  clear EX/MEM control bits at the next edge
o_State_2  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH
o_StallCount  out  CNT_WIDTH  total stall cycles
o_FlushCount  out  CNT_WIDTH  total flush events
o_Error  out  1  sticky watchdog flag

Behaviour:
- Reset (reset = 0, asynchronous):
  - all scoreboard entries invalid; state RUN; counters 0; o_Error 0.
  - o_PCEnable = 1 and o_IF_ID_Enable = 1; all flush outputs 0.
- Scoreboard entry = {valid, dest[4:0]}. An entry is valid only if RegWrite = 1 and dest != 0.
- Hazard (combinational):
  - in_IDValid and (in_UsesRs and rs != 0 and rs matches a valid entry, or the same for rt).
  - Entries checked: sb_ex and sb_mem always; sb_wb only when WB_BYPASS = 0.
- Output priority, evaluated in the same cycle: MEM branch flush > EX jump flush > stall > run.
  - Branch flush: o_IF_ID_Flush = 1, o_ID_EX_Flush = 1, o_EX_MEM_Flush = 1; enables = 1 so the PC loads the target.
  - Jump flush: o_IF_ID_Flush = 1, o_ID_EX_Flush = 1; enables = 1.
  - Stall: o_PCEnable = 0, o_IF_ID_Enable = 0, o_ID_EX_Flush = 1.
  - Run: enables = 1, flushes = 0.
- Scoreboard update at each rising edge:
  - sb_wb <= sb_mem.
  - sb_mem <= branch flush ? invalid : sb_ex.
  - sb_ex <= (any flush or stall) ? invalid : ID entry.
- FSM:
  - Next state = FLUSH on any flush, else STALL on hazard, else RUN.
  - o_State_2 is registered, so it reflects the previous cycle's decision (diagnostic, one cycle late).
  - Simultaneous branch and jump count as one flush event.
- Counters:
  - o_StallCount += 1 on each stall cycle; o_FlushCount += 1 on each flush cycle.
  - Both wrap modulo 2^CNT_WIDTH.
- Watchdog:
  - A run counter increments on consecutive stall cycles and clears on any non-stall cycle.
  - When it exceeds STALL_LIMIT, o_Error is set and stays set until reset; the pipeline is not otherwise affected.
- Latency: stall/flush decisions are combinational from inputs and the registered scoreboard; zero-cycle response.
- Reset mid-stall or mid-flush: everything returns to reset values immediately; no pending flush survives.

Decomposition:
- Shared package: state encodings (RUN / STALL / FLUSH), scoreboard entry width (6), the REG_ZERO constant.
- One sub-module, hazard_scoreboard: the 3-entry shift register plus the match comparators, outputting a hazard flag.
- FSM, counters and watchdog stay in the top module.

Test Plan:
- add $3 in ID with sb_ex = {1,$3} and WB_BYPASS = 0:
  - 3 stall cycles (o_PCEnable = 0, o_ID_EX_Flush = 1);
  - proceeds in the 4th cycle; o_StallCount = 3; o_Error = 0.
- Same case with WB_BYPASS = 1 → 2 stall cycles, o_StallCount = 2.
- Write to $0 in EX, then ID reads $0 → no stall; sb_ex stays invalid.
- in_MEMBranchTaken = 1 while a hazard is present:
  - all three flushes = 1, enables = 1, o_FlushCount = 1;
  - next cycle sb_ex and sb_mem invalid, o_State_2 = 2.
- in_EXJump = 1 and in_MEMBranchTaken = 1 together → branch flush pattern, o_FlushCount increments by 1 only.
- Forced hazard held for 4 cycles with STALL_LIMIT = 3 → o_Error rises on the 4th stall cycle, stays 1 after the hazard clears, returns to 0 on reset = 0.
